// File: rtl/switch_input_pkg.sv
// Shared constants for the switch/pushbutton input port: register map and
// edge-capture mode encodings.
package switch_input_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE encodings
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/switch_debounce.sv
// Single-bit debouncer: the output follows the (already synchronised) input
// only after the input has differed from it for DB_CYCLES consecutive clocks.
module switch_debounce #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CW        = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  // Count while the input disagrees with the output; any agreement restarts the count
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (d_i != q_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        q_d   = d_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/switch_input_port.sv
// Avalon-MM slave for slider switches / pushbuttons: 2-flop synchroniser,
// optional per-bit debounce (SWITCH_INPUT_DEBOUNCE_EN), edge capture with W1C,
// interrupt mask and a registered level IRQ.
module switch_input_port
  import switch_input_pkg::*;
#(
  parameter int unsigned DW        = 9,
  parameter int unsigned EDGE_TYPE = 0,
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    address,
  input  logic [3:0]    byteenable,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [DW:0]   SW,
  output logic [31:0]   readdata,
  output logic          irq
);

  logic [DW:0] sync1_q, sync2_q, filtered, prev_q;
  logic [DW:0] edge_cap_q, edge_cap_d, mask_q, mask_d;
  logic [DW:0] rise, fall, edge_set, w1c;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_q;
  logic        wr_en;

  // Reads are decoded from chipselect alone and writes are full-word
  logic unused_bus;
  assign unused_bus = ^{read, byteenable, writedata};

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_INPUT_DEBOUNCE_EN
  for (genvar i = 0; i <= int'(DW); i++) begin : g_db
    switch_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CW        (CW)
    ) u_db (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    (sync2_q[i]),
      .q_o    (filtered[i])
    );
  end
`else
  assign filtered = sync2_q;

  logic [31:0] unused_db_cfg;
  assign unused_db_cfg = DB_CYCLES ^ CW;
`endif

  assign rise  = filtered & ~prev_q;
  assign fall  = ~filtered & prev_q;
  assign wr_en = chipselect & write;

  // Select which transitions set capture bits
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      EDGE_ANY:  edge_set = rise | fall;
      default:   edge_set = rise;
    endcase
  end

  // Register writes; a new edge overrides a simultaneous W1C on the same bit
  always_comb begin
    mask_d     = mask_q;
    w1c        = '0;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[DW:0];
    if (wr_en && address == ADDR_EDGE) w1c = writedata[DW:0];
    edge_cap_d = (edge_cap_q & ~w1c) | edge_set;
  end

  // Read mux; readdata holds when not selected
  always_comb begin
    readdata_d = readdata_q;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata_d = 32'(filtered);
        ADDR_RSVD: readdata_d = '0;
        ADDR_MASK: readdata_d = 32'(mask_q);
        ADDR_EDGE: readdata_d = 32'(edge_cap_q);
        default:   readdata_d = '0;
      endcase
    end
  end

  // Edge history, capture/mask registers, read data and IRQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edge_cap_q <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= filtered;
      edge_cap_q <= edge_cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edge_cap_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port: a rising-edge instance and an
// any-edge instance share the bus and switch inputs.
module tb_switch_input_port;

  localparam int unsigned DW = 9;
`ifdef SWITCH_INPUT_DEBOUNCE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [DW:0] SW;
  logic [31:0] readdata, rd_any;
  logic        irq, irq_any;

  int checks;
  int errors;

  switch_input_port #(
    .DW        (DW),
    .EDGE_TYPE (0),
    .DB_CYCLES (8),
    .CW        (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .SW         (SW),
    .readdata   (readdata),
    .irq        (irq)
  );

  switch_input_port #(
    .DW        (DW),
    .EDGE_TYPE (2),
    .DB_CYCLES (8),
    .CW        (4)
  ) dut_any (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .SW         (SW),
    .readdata   (rd_any),
    .irq        (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    step();
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = '0;
    byteenable = 4'hf;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    SW         = '1;

    // Reset with all switches high
    repeat (3) step();
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_any_readdata", rd_any, 32'h0);
    reset_n = 1'b1;
    repeat (LAT + 2) step();
    bus_rd(2'd0);
    check("data_all_ones", readdata, 32'h3ff);
    check("any_data_all_ones", rd_any, 32'h3ff);
    step();
    check("readdata_hold", readdata, 32'h3ff);

    // Drop all switches and clear the captures left over from reset release
    SW = '0;
    repeat (LAT + 3) step();
    bus_rd(2'd0);
    check("data_zero", readdata, 32'h0);
    bus_wr(2'd3, 32'h3ff);
    bus_rd(2'd3);
    check("edge_cleared", readdata, 32'h0);
    check("any_edge_cleared", rd_any, 32'h0);

    // Rising capture on bit 0 with mask bit 0
    bus_wr(2'd2, 32'h1);
    SW[0] = 1'b1;
    repeat (LAT + 3) step();
    check("rise0_irq", 32'(irq), 32'h1);
    bus_rd(2'd3);
    check("rise0_edge", readdata, 32'h1);
    bus_wr(2'd3, 32'h1);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    bus_rd(2'd3);
    check("w1c_edge", readdata, 32'h0);
    check("w1c_irq", 32'(irq), 32'h0);

    // Edge on bit 3 lands in the same cycle as a W1C of bit 3
    SW[3] = 1'b1;
    repeat (LAT) step();
    bus_wr(2'd3, 32'h8);
    bus_rd(2'd3);
    check("set_beats_clear", readdata, 32'h8);
    check("set_masked_irq", 32'(irq), 32'h0);
    bus_wr(2'd3, 32'h8);
    bus_rd(2'd3);
    check("clear_bit3", readdata, 32'h0);

    // Mask gating on bit 5
    bus_wr(2'd2, 32'h0);
    SW[5] = 1'b1;
    repeat (LAT + 3) step();
    bus_rd(2'd3);
    check("mask_gate_edge", readdata, 32'h20);
    check("mask_gate_irq", 32'(irq), 32'h0);
    bus_wr(2'd2, 32'h20);
    check("unmask_irq_lag", 32'(irq), 32'h0);
    step();
    check("unmask_irq", 32'(irq), 32'h1);
    bus_rd(2'd2);
    check("mask_read", readdata, 32'h20);
    bus_wr(2'd2, 32'h0);
    step();
    check("remask_irq", 32'(irq), 32'h0);
    bus_rd(2'd3);
    check("remask_edge_kept", readdata, 32'h20);

    // Reserved read, ignored data write, upper bits zero
    bus_rd(2'd1);
    check("rsvd_read", readdata, 32'h0);
    bus_wr(2'd0, 32'hffff_ffff);
    bus_rd(2'd0);
    check("data_write_ignored", readdata, 32'h29);
    bus_wr(2'd2, 32'hffff_ffff);
    bus_rd(2'd2);
    check("mask_upper_zero", readdata, 32'h3ff);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd3, 32'h3ff);

    // Both-edge capture on bit 1
    SW[1] = 1'b1;
    repeat (LAT + 3) step();
    bus_rd(2'd3);
    check("rise1_edge", readdata, 32'h2);
    check("any_rise1_edge", rd_any, 32'h2);
    bus_wr(2'd3, 32'h2);
    SW[1] = 1'b0;
    repeat (LAT + 3) step();
    bus_rd(2'd3);
    check("fall1_no_rise_edge", readdata, 32'h0);
    check("any_fall1_edge", rd_any, 32'h2);

`ifdef SWITCH_INPUT_DEBOUNCE_EN
    // Short pulse rejected, long hold accepted after 2 + DB_CYCLES clocks
    bus_wr(2'd3, 32'h3ff);
    SW[2] = 1'b1;
    repeat (5) step();
    SW[2] = 1'b0;
    repeat (12) step();
    bus_rd(2'd0);
    check("db_pulse_rejected", readdata, 32'h29);
    SW[2]      = 1'b1;
    chipselect = 1'b1;
    address    = 2'd0;
    repeat (10) step();
    check("db_before_accept", readdata, 32'h29);
    step();
    check("db_accept", readdata, 32'h2d);
    chipselect = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
